phase_diff_meter: RTL and testbench
===================================

// Module: phase_diff_meter
// PURPOSE
// - Measures the phase difference between the 5 MHz ADPLL reference and the feedback clock.
// - Counts ticks of the 400 MHz clock from the first rising edge to the other signal's rising edge.
// - Both inputs arrive as data, not as clocks, and are asynchronous to clk400_i.
// - Its signed result drives the ADPLL loop filter.
// PARAMETERS
// - SYNC_STAGES  2    flip-flops in each input synchroniser (min 2)
// - CNT_W        8    tick counter width; diff_o is CNT_W+1 bits, signed
// - MAX_CNT      79   timeout limit in ticks (one 5 MHz period minus 1)
// - LOCK_TOL     2    |diff| at or below this value counts as in-lock (PDIFF_LOCK_DET_EN only)
// - LOCK_COUNT   16   consecutive in-lock results needed to assert locked_o
// PORTS
// - clk400_i      in   1        400 MHz clock; the only clock in this block
// - rst_n_i       in   1        reset: asynchronous assert, active-low
// - ref_i         in   1        reference square wave, asynchronous
// - fb_i          in   1        feedback square wave, asynchronous
// - diff_o        out  CNT_W+1  signed two's-complement ticks; positive = fb lags ref
// - diff_valid_o  out  1        one-cycle pulse: new diff_o value
// - timeout_o     out  1        one-cycle pulse: measurement abandoned
// - locked_o      out  1        lock indicator; tied 0 without PDIFF_LOCK_DET_EN
// BEHAVIOUR
// - Reset (rst_n_i=0, async):
//   - state=IDLE; diff_o=0; diff_valid_o=0; timeout_o=0; locked_o=0.
//   - Synchronisers, previous-value flops and counters cleared.
// - Warm-up: rising-edge detection is disabled for SYNC_STAGES+1 cycles after reset release.
//   - This stops a high input from giving a false edge at reset release.
// - Edge detect: ref_e/fb_e = synced & ~prev. The edge reaches the FSM SYNC_STAGES+1 cycles after the pin.
// - FSM states: IDLE, REF_LEAD, FB_LEAD.
//   - IDLE, ref_e and fb_e in the same cycle: diff_o=0, pulse valid, stay IDLE.
//   - IDLE, ref_e only: cnt=1, go to REF_LEAD.
//   - IDLE, fb_e only: cnt=1, go to FB_LEAD.
//   - REF_LEAD, fb_e: diff_o=+cnt, pulse valid, go to IDLE.
//   - FB_LEAD, ref_e: diff_o=-cnt, pulse valid, go to IDLE.
//   - Otherwise in a LEAD state: cnt++.
//   - LEAD state, the same signal's edge again before the other: pulse timeout_o, cnt=1, stay in the state (re-armed).
//   - LEAD state, both edges in one cycle: the other edge closes the measurement, then the same edge opens a new one (cnt=1).
//   - LEAD state, cnt reaches MAX_CNT: pulse timeout_o, go to IDLE, diff_o holds.
// - Outputs are registered; diff_valid_o rises on the clock edge after the closing edge is detected.
// - diff_o holds its value between valid pulses.
// - cnt never exceeds MAX_CNT, so it never wraps; MAX_CNT must be < 2**CNT_W.
// - Reset asserted mid-measurement: abort at once, no valid or timeout pulse, warm-up restarts.
// CONFIGURATION
// - Macro PDIFF_LOCK_DET_EN.
// - Defined:
//   - A streak counter of clog2(LOCK_COUNT+1) bits counts valid results with |diff|<=LOCK_TOL.
//   - An out-of-tolerance valid result or a timeout clears the streak and locked_o.
//   - The streak saturates at LOCK_COUNT; locked_o=1 the cycle after it reaches LOCK_COUNT.
// - Undefined: no streak logic; locked_o is constant 0.
// STRUCTURE
// - Shared package pdiff_pkg: FSM state encoding (IDLE=2'd0, REF_LEAD=2'd1, FB_LEAD=2'd2), default widths, MAX_CNT.
// - Sub-module pdiff_sync_edge: SYNC_STAGES synchroniser, prev flop and warm-up gating.
//   - Outputs a one-cycle rise pulse.
//   - Instantiated twice, once for ref and once for fb.
// - Top level: FSM, tick counter, output registers, optional lock detector.
// TESTING
// - Reset, then fb rises 12 ticks after ref -> diff_o=+12 with one diff_valid_o pulse, timeout_o=0.
// - fb rises 30 ticks before ref -> diff_o=-30 (9'h1E2), one valid pulse.
// - ref and fb rise on the same clk400 edge -> diff_o=0, valid pulse, FSM back in IDLE.
// - fb held low, ref toggling at 5 MHz -> timeout_o pulses, diff_o unchanged, no valid pulse.
// - ref_i=fb_i=1 during reset release -> no edge, valid or timeout for the first 3 cycles.
// - PDIFF_LOCK_DET_EN: 16 results of diff=+1 -> locked_o=1; next result +5 -> locked_o=0 next cycle.

Source files
------------

// File: rtl/pdiff_pkg.sv
// rtl/pdiff_pkg.sv - shared FSM encoding and default sizing for the phase difference meter
package pdiff_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REF_LEAD = 2'd1,
        FB_LEAD  = 2'd2
    } pdiff_state_t;

    localparam int PDIFF_SYNC_STAGES = 2;
    localparam int PDIFF_CNT_W       = 8;
    localparam int PDIFF_MAX_CNT     = 79;
    localparam int PDIFF_LOCK_TOL    = 2;
    localparam int PDIFF_LOCK_COUNT  = 16;

endpackage

// File: rtl/pdiff_sync_edge.sv
// rtl/pdiff_sync_edge.sv - input synchroniser with warm-up gated, registered rising-edge pulse
module pdiff_sync_edge
    import pdiff_pkg::*;
#(
    parameter int SYNC_STAGES = PDIFF_SYNC_STAGES
) (
    input  logic clk400_i,
    input  logic rst_n_i,
    input  logic async_i,
    output logic rise_o
);

    localparam int WARM   = SYNC_STAGES + 1;
    localparam int WARM_W = $clog2(WARM + 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic                   r_rise;
    logic [WARM_W-1:0]      r_warm;
    logic                   w_warm_done;

    assign w_warm_done = (r_warm == WARM_W'(WARM));

    // Edges are suppressed until the chain and prev flop hold real samples,
    // so a pin already high at reset release never looks like a rise.
    always_ff @(posedge clk400_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sync <= '0;
            r_prev <= 1'b0;
            r_rise <= 1'b0;
            r_warm <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_i};
            r_prev <= r_sync[SYNC_STAGES-1];
            r_rise <= w_warm_done & r_sync[SYNC_STAGES-1] & ~r_prev;
            if (!w_warm_done) begin
                r_warm <= r_warm + 1'b1;
            end
        end
    end

    assign rise_o = r_rise;

endmodule

// File: rtl/phase_diff_meter.sv
// rtl/phase_diff_meter.sv - signed ref/fb phase difference in 400 MHz ticks for the ADPLL loop filter
// Optional lock detector enabled by defining PDIFF_LOCK_DET_EN.
module phase_diff_meter
    import pdiff_pkg::*;
#(
    parameter int SYNC_STAGES = PDIFF_SYNC_STAGES,
    parameter int CNT_W       = PDIFF_CNT_W,
    parameter int MAX_CNT     = PDIFF_MAX_CNT,
    parameter int LOCK_TOL    = PDIFF_LOCK_TOL,
    parameter int LOCK_COUNT  = PDIFF_LOCK_COUNT
) (
    input  logic                    clk400_i,
    input  logic                    rst_n_i,
    input  logic                    ref_i,
    input  logic                    fb_i,
    output logic signed [CNT_W:0]   diff_o,
    output logic                    diff_valid_o,
    output logic                    timeout_o,
    output logic                    locked_o
);

    generate
        if (SYNC_STAGES < 2 || MAX_CNT < 1 || MAX_CNT >= (2 ** CNT_W) ||
            LOCK_COUNT < 1 || LOCK_TOL < 0) begin : g_bad_cfg
            $error("phase_diff_meter: illegal parameter combination");
        end
    endgenerate

    logic w_ref_e;
    logic w_fb_e;

    pdiff_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
        .clk400_i (clk400_i),
        .rst_n_i  (rst_n_i),
        .async_i  (ref_i),
        .rise_o   (w_ref_e)
    );

    pdiff_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_fb_sync (
        .clk400_i (clk400_i),
        .rst_n_i  (rst_n_i),
        .async_i  (fb_i),
        .rise_o   (w_fb_e)
    );

    pdiff_state_t          r_state;
    pdiff_state_t          w_state_n;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_n;
    logic signed [CNT_W:0] r_diff;
    logic signed [CNT_W:0] w_diff_n;
    logic                  r_valid;
    logic                  w_valid_n;
    logic                  r_timeout;
    logic                  w_timeout_n;
    logic signed [CNT_W:0] w_pos;
    logic signed [CNT_W:0] w_neg;
    logic                  w_at_max;

    assign w_pos    = $signed({1'b0, r_cnt});
    assign w_neg    = -w_pos;
    assign w_at_max = (r_cnt >= CNT_W'(MAX_CNT));

    always_ff @(posedge clk400_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_diff    <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_diff    <= w_diff_n;
            r_valid   <= w_valid_n;
            r_timeout <= w_timeout_n;
        end
    end

    // In a LEAD state the other edge is checked first, so a simultaneous pair
    // closes the running measurement and the leader's edge reopens a new one.
    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        w_diff_n    = r_diff;
        w_valid_n   = 1'b0;
        w_timeout_n = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ref_e && w_fb_e) begin
                    w_diff_n  = '0;
                    w_valid_n = 1'b1;
                end else if (w_ref_e) begin
                    w_cnt_n   = CNT_W'(1);
                    w_state_n = REF_LEAD;
                end else if (w_fb_e) begin
                    w_cnt_n   = CNT_W'(1);
                    w_state_n = FB_LEAD;
                end
            end
            REF_LEAD: begin
                if (w_fb_e) begin
                    w_diff_n  = w_pos;
                    w_valid_n = 1'b1;
                    if (w_ref_e) begin
                        w_cnt_n = CNT_W'(1);
                    end else begin
                        w_state_n = IDLE;
                    end
                end else if (w_ref_e) begin
                    w_timeout_n = 1'b1;
                    w_cnt_n     = CNT_W'(1);
                end else if (w_at_max) begin
                    w_timeout_n = 1'b1;
                    w_state_n   = IDLE;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            FB_LEAD: begin
                if (w_ref_e) begin
                    w_diff_n  = w_neg;
                    w_valid_n = 1'b1;
                    if (w_fb_e) begin
                        w_cnt_n = CNT_W'(1);
                    end else begin
                        w_state_n = IDLE;
                    end
                end else if (w_fb_e) begin
                    w_timeout_n = 1'b1;
                    w_cnt_n     = CNT_W'(1);
                end else if (w_at_max) begin
                    w_timeout_n = 1'b1;
                    w_state_n   = IDLE;
                end else begin
                    w_cnt_n = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_n = IDLE;
            end
        endcase
    end

    assign diff_o       = r_diff;
    assign diff_valid_o = r_valid;
    assign timeout_o    = r_timeout;

`ifdef PDIFF_LOCK_DET_EN
    localparam int STREAK_W = $clog2(LOCK_COUNT + 1);
    localparam logic signed [CNT_W:0] TOL = (CNT_W + 1)'(LOCK_TOL);

    logic [STREAK_W-1:0] r_streak;
    logic                r_locked;
    logic                w_in_tol;

    assign w_in_tol = (r_diff <= TOL) && (r_diff >= -TOL);

    // Works from the registered result, so locked_o trails the valid pulse.
    always_ff @(posedge clk400_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_streak <= '0;
            r_locked <= 1'b0;
        end else if (r_timeout || (r_valid && !w_in_tol)) begin
            r_streak <= '0;
            r_locked <= 1'b0;
        end else begin
            if (r_valid && (r_streak != STREAK_W'(LOCK_COUNT))) begin
                r_streak <= r_streak + 1'b1;
            end
            r_locked <= (r_streak == STREAK_W'(LOCK_COUNT));
        end
    end

    assign locked_o = r_locked;
`else
    assign locked_o = 1'b0;
`endif

endmodule

// File: tb/tb_phase_diff_meter.sv
// tb/tb_phase_diff_meter.sv - table-driven directed bench for phase_diff_meter
`timescale 1ns/1ps
module tb_phase_diff_meter;
    import pdiff_pkg::*;

    localparam int NEVER = 100000;

    logic              clk;
    logic              rst_n;
    logic              ref_i;
    logic              fb_i;
    logic signed [8:0] diff_o;
    logic              diff_valid_o;
    logic              timeout_o;
    logic              locked_o;

    phase_diff_meter dut (
        .clk400_i     (clk),
        .rst_n_i      (rst_n),
        .ref_i        (ref_i),
        .fb_i         (fb_i),
        .diff_o       (diff_o),
        .diff_valid_o (diff_valid_o),
        .timeout_o    (timeout_o),
        .locked_o     (locked_o)
    );

    initial clk = 1'b0;
    always #1.25 clk = ~clk;

    typedef struct {
        string name;
        int    ref_rise;
        int    fb_rise;
        int    exp_valid;
        int    exp_to;
        int    exp_diff;
    } vec_t;

    vec_t vecs[9];

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid;
    int n_to;
    int first_diff;
    int last_diff;
    int lock_after;
    bit pend_lock;

`ifdef PDIFF_LOCK_DET_EN
    localparam int EXP_LOCK = 1;
`else
    localparam int EXP_LOCK = 0;
`endif

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_counts();
        n_valid    = 0;
        n_to       = 0;
        first_diff = 0;
        last_diff  = 0;
        lock_after = -1;
        pend_lock  = 1'b0;
    endtask

    task automatic sample_cycle();
        @(posedge clk);
        #1;
        if (pend_lock) begin
            lock_after = int'(locked_o);
            pend_lock  = 1'b0;
        end
        if (diff_valid_o) begin
            if (n_valid == 0) first_diff = int'(diff_o);
            last_diff = int'(diff_o);
            n_valid++;
            pend_lock = 1'b1;
        end
        if (timeout_o) n_to++;
    endtask

    // Each pin is high in [x0,x1) and from x2 onward; both drop after win cycles.
    task automatic run_wave(input int r0, input int r1, input int r2,
                            input int f0, input int f1, input int f2, input int win);
        clear_counts();
        for (int c = 0; c < win + 20; c++) begin
            @(negedge clk);
            if (c < win) begin
                ref_i = (c >= r0 && c < r1) || (c >= r2);
                fb_i  = (c >= f0 && c < f1) || (c >= f2);
            end else begin
                ref_i = 1'b0;
                fb_i  = 1'b0;
            end
            sample_cycle();
        end
    endtask

    initial begin
        vecs[0] = '{"fb_lag_12",     5,    17,    1, 0,  12};
        vecs[1] = '{"fb_lead_30",    35,   5,     1, 0, -30};
        vecs[2] = '{"same_edge",     5,    5,     1, 0,   0};
        vecs[3] = '{"max_cnt_79",    5,    84,    1, 0,  79};
        vecs[4] = '{"past_max_80",   5,    85,    0, 2,  79};
        vecs[5] = '{"fb_lead_1",     6,    5,     1, 0,  -1};
        vecs[6] = '{"ref_only",      5,    NEVER, 0, 1,  -1};
        vecs[7] = '{"fb_past_max",   90,   10,    0, 2,  -1};
        vecs[8] = '{"fb_lag_1",      20,   21,    1, 0,   1};

        // Reset with both inputs high: no false edge after release.
        rst_n = 1'b0;
        ref_i = 1'b1;
        fb_i  = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_diff",    int'(diff_o),       0);
        chk("rst_valid",   int'(diff_valid_o), 0);
        chk("rst_timeout", int'(timeout_o),    0);
        chk("rst_locked",  int'(locked_o),     0);
        chk("rst_state",   int'(dut.r_state),  int'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        clear_counts();
        repeat (12) sample_cycle();
        chk("warmup_valid",   n_valid, 0);
        chk("warmup_timeout", n_to,    0);
        chk("warmup_state",   int'(dut.r_state), int'(IDLE));
        @(negedge clk);
        ref_i = 1'b0;
        fb_i  = 1'b0;
        repeat (8) sample_cycle();

        for (int i = 0; i < 9; i++) begin
            run_wave(vecs[i].ref_rise, NEVER, NEVER, vecs[i].fb_rise, NEVER, NEVER, 260);
            chk({vecs[i].name, "_valid"},   n_valid,            vecs[i].exp_valid);
            chk({vecs[i].name, "_timeout"}, n_to,               vecs[i].exp_to);
            chk({vecs[i].name, "_diff"},    int'(diff_o),       vecs[i].exp_diff);
            chk({vecs[i].name, "_state"},   int'(dut.r_state),  int'(IDLE));
        end

        // ref toggling at 5 MHz with fb held low: one timeout per ref edge.
        clear_counts();
        for (int c = 0; c < 420; c++) begin
            @(negedge clk);
            ref_i = (c < 320) && ((c % 80) >= 5) && ((c % 80) < 45);
            fb_i  = 1'b0;
            sample_cycle();
        end
        chk("toggle_timeout", n_to,         4);
        chk("toggle_valid",   n_valid,      0);
        chk("toggle_diff",    int'(diff_o), 1);

        // Second ref edge before fb re-arms the count.
        run_wave(5, 25, 45, 55, NEVER, NEVER, 120);
        chk("rearm_timeout", n_to,      1);
        chk("rearm_valid",   n_valid,   1);
        chk("rearm_diff",    last_diff, 10);

        // Both edges in one cycle while REF_LEAD: close then reopen.
        run_wave(5, 15, 25, 25, 30, 38, 120);
        chk("both_valid",   n_valid,    2);
        chk("both_first",   first_diff, 20);
        chk("both_second",  last_diff,  13);
        chk("both_timeout", n_to,       0);
        chk("both_state",   int'(dut.r_state), int'(IDLE));

        // Asynchronous reset in the middle of a measurement.
        clear_counts();
        @(negedge clk);
        ref_i = 1'b1;
        repeat (10) sample_cycle();
        #0.1;
        rst_n = 1'b0;
        ref_i = 1'b0;
        #0.05;
        chk("abort_diff",  int'(diff_o),      0);
        chk("abort_state", int'(dut.r_state), int'(IDLE));
        chk("abort_valid", int'(diff_valid_o), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clear_counts();
        repeat (120) sample_cycle();
        chk("abort_after_valid",   n_valid, 0);
        chk("abort_after_timeout", n_to,    0);

        // Lock streak: 16 in-tolerance results, then one out of tolerance.
        for (int k = 0; k < 15; k++) begin
            run_wave(2, 10, NEVER, 3, 10, NEVER, 16);
        end
        chk("lock_after15", int'(locked_o), 0);
        run_wave(2, 10, NEVER, 3, 10, NEVER, 16);
        chk("lock_diff16",  last_diff,      1);
        chk("lock_after16", int'(locked_o), EXP_LOCK);
        run_wave(2, 10, NEVER, 7, 10, NEVER, 16);
        chk("unlock_diff",   last_diff,  5);
        chk("unlock_next",   lock_after, 0);
        chk("unlock_locked", int'(locked_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
